// File: rtl/fault_diagnosis_writer_if.sv
// Bus between the self-test comparator, the fault diagnosis writer and the eNVM faulty-PE storage.
// slave = writer view, master = driver/observer view.
interface fault_diagnosis_writer_if #(
    parameter int SYSTOLIC_SIZE = 8,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE),
    parameter int COUNT_WIDTH   = $clog2(SYSTOLIC_SIZE * SYSTOLIC_SIZE) + 1
);
    // Handshake: no ready exists on either side. result_valid is taken unconditionally on
    // any rising edge in ACCUM; detection_en is a write strobe the eNVM must accept on the
    // edge that ends the cycle in which it is high; start/test_done are single-cycle pulses.
    logic                     start;
    logic                     result_valid;
    logic [ADDR_WIDTH-1:0]    result_row;
    logic [SYSTOLIC_SIZE-1:0] result_mismatch;
    logic                     test_done;
    logic                     busy;
    logic                     done;
    logic                     detection_en;
    logic [ADDR_WIDTH-1:0]    detection_addr;
    logic [SYSTOLIC_SIZE-1:0] single_pe_detection;
    logic                     row_fault_detection;
    logic                     column_fault_detection;
    logic [COUNT_WIDTH-1:0]   fault_count;
    logic [2:0]               fsm_state;

    modport slave (
        input  start, result_valid, result_row, result_mismatch, test_done,
        output busy, done, detection_en, detection_addr, single_pe_detection,
               row_fault_detection, column_fault_detection, fault_count, fsm_state
    );

    modport master (
        output start, result_valid, result_row, result_mismatch, test_done,
        input  busy, done, detection_en, detection_addr, single_pe_detection,
               row_fault_detection, column_fault_detection, fault_count, fsm_state
    );
endinterface

// File: rtl/fault_diagnosis_writer.sv
// Accumulates a PE fail map, classifies row/column/single faults and streams them to the eNVM.
// Optional macro ROW_COL_CLASSIFY_EN enables row/column classification (off: raw fail map is written).
module fault_diagnosis_writer #(
    parameter int SYSTOLIC_SIZE       = 8,
    parameter int ADDR_WIDTH          = $clog2(SYSTOLIC_SIZE),
    parameter int ROW_FAULT_THRESHOLD = 4,
    parameter int COL_FAULT_THRESHOLD = 4,
    parameter int COUNT_WIDTH         = $clog2(SYSTOLIC_SIZE * SYSTOLIC_SIZE) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fault_diagnosis_writer_if.slave     bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ACCUM, S_CLASSIFY, S_WRITE, S_FINISH
    } state_t;

    if (ROW_FAULT_THRESHOLD < 1 || ROW_FAULT_THRESHOLD > SYSTOLIC_SIZE ||
        COL_FAULT_THRESHOLD < 1 || COL_FAULT_THRESHOLD > SYSTOLIC_SIZE) begin : g_bad_threshold
        $error("fault thresholds must lie in 1..SYSTOLIC_SIZE");
    end

    state_t state, state_next;

    logic [SYSTOLIC_SIZE-1:0] fail_map [SYSTOLIC_SIZE];
    logic [SYSTOLIC_SIZE-1:0] row_fault, col_fault;
    logic [SYSTOLIC_SIZE-1:0] row_fault_c, col_fault_c;
    logic [COUNT_WIDTH-1:0]   row_pop [SYSTOLIC_SIZE];
    logic [COUNT_WIDTH-1:0]   total_c;
    logic [COUNT_WIDTH-1:0]   fault_count;
    logic [ADDR_WIDTH-1:0]    cnt;
    logic                     last_write;

    logic                     done, detection_en, row_fault_detection, column_fault_detection;
    logic [ADDR_WIDTH-1:0]    detection_addr;
    logic [SYSTOLIC_SIZE-1:0] single_pe_detection;

    assign last_write = (cnt == ADDR_WIDTH'(SYSTOLIC_SIZE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (bus.start)     state_next = S_ACCUM;
            S_ACCUM:    if (bus.test_done) state_next = S_CLASSIFY;
            S_CLASSIFY: state_next = S_WRITE;
            S_WRITE:    if (last_write)    state_next = S_FINISH;
            S_FINISH:   state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        total_c = '0;
        for (int r = 0; r < SYSTOLIC_SIZE; r++) begin
            row_pop[r] = '0;
            for (int c = 0; c < SYSTOLIC_SIZE; c++)
                row_pop[r] = row_pop[r] + COUNT_WIDTH'(fail_map[r][c]);
            total_c = total_c + row_pop[r];
        end
    end

`ifdef ROW_COL_CLASSIFY_EN
    logic [COUNT_WIDTH-1:0] col_pop [SYSTOLIC_SIZE];

    always_comb begin
        for (int c = 0; c < SYSTOLIC_SIZE; c++) begin
            col_pop[c] = '0;
            for (int r = 0; r < SYSTOLIC_SIZE; r++)
                col_pop[c] = col_pop[c] + COUNT_WIDTH'(fail_map[r][c]);
        end
        for (int i = 0; i < SYSTOLIC_SIZE; i++) begin
            row_fault_c[i] = row_pop[i] >= COUNT_WIDTH'(ROW_FAULT_THRESHOLD);
            col_fault_c[i] = col_pop[i] >= COUNT_WIDTH'(COL_FAULT_THRESHOLD);
        end
    end
`else
    assign row_fault_c = '0;
    assign col_fault_c = '0;
`endif

    // Datapath follows the registered state; outputs are registered, so each write
    // appears one cycle after the WRITE cycle that selects its row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < SYSTOLIC_SIZE; r++) fail_map[r] <= '0;
            row_fault              <= '0;
            col_fault              <= '0;
            fault_count            <= '0;
            cnt                    <= '0;
            done                   <= 1'b0;
            detection_en           <= 1'b0;
            detection_addr         <= '0;
            single_pe_detection    <= '0;
            row_fault_detection    <= 1'b0;
            column_fault_detection <= 1'b0;
        end else begin
            done <= (state == S_FINISH);
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        for (int r = 0; r < SYSTOLIC_SIZE; r++) fail_map[r] <= '0;
                        fault_count <= '0;
                    end
                end
                S_ACCUM: begin
                    if (bus.result_valid)
                        fail_map[bus.result_row] <= fail_map[bus.result_row] | bus.result_mismatch;
                end
                S_CLASSIFY: begin
                    row_fault   <= row_fault_c;
                    col_fault   <= col_fault_c;
                    fault_count <= total_c;
                    cnt         <= '0;
                end
                S_WRITE: begin
                    detection_en           <= 1'b1;
                    detection_addr         <= cnt;
                    single_pe_detection    <= row_fault[cnt] ? '0 : (fail_map[cnt] & ~col_fault);
                    row_fault_detection    <= row_fault[cnt];
                    column_fault_detection <= col_fault[cnt];
                    if (!last_write) cnt <= cnt + 1'b1;
                end
                S_FINISH: begin
                    detection_en           <= 1'b0;
                    detection_addr         <= '0;
                    single_pe_detection    <= '0;
                    row_fault_detection    <= 1'b0;
                    column_fault_detection <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy                   = (state != S_IDLE);
    assign bus.done                   = done;
    assign bus.detection_en           = detection_en;
    assign bus.detection_addr         = detection_addr;
    assign bus.single_pe_detection    = single_pe_detection;
    assign bus.row_fault_detection    = row_fault_detection;
    assign bus.column_fault_detection = column_fault_detection;
    assign bus.fault_count            = fault_count;
    assign bus.fsm_state              = state;
endmodule

// File: tb/tb_fault_diagnosis_writer.sv
// Directed bench for fault_diagnosis_writer: fixed-latency write sequences checked against hand-computed maps.
module tb_fault_diagnosis_writer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    fault_diagnosis_writer_if bus ();

    fault_diagnosis_writer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
    endtask

    task automatic send(input logic [2:0] row, input logic [7:0] mism, input logic td, input logic st);
        bus.result_valid    = 1'b1;
        bus.result_row      = row;
        bus.result_mismatch = mism;
        bus.test_done       = td;
        bus.start           = st;
        cycle();
        bus.result_valid    = 1'b0;
        bus.result_row      = '0;
        bus.result_mismatch = '0;
        bus.test_done       = 1'b0;
        bus.start           = 1'b0;
    endtask

    task automatic finish_test();
        bus.test_done = 1'b1;
        cycle();
        bus.test_done = 1'b0;
    endtask

    // Entered at the negedge right after test_done was sampled; row k of map is byte k.
    task automatic run_writes(input string tag, input logic [63:0] map, input logic [7:0] rowv,
                              input logic [7:0] colv, input logic [6:0] count);
        check({tag, " busy_classify"}, 64'(bus.busy), 64'd1);
        cycle();
        check({tag, " en_pre"}, 64'(bus.detection_en), 64'd0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            check($sformatf("%s en[%0d]", tag, k), 64'(bus.detection_en), 64'd1);
            check($sformatf("%s addr[%0d]", tag, k), 64'(bus.detection_addr), 64'(k));
            check($sformatf("%s single[%0d]", tag, k), 64'(bus.single_pe_detection), 64'(map[k*8 +: 8]));
            check($sformatf("%s rowf[%0d]", tag, k), 64'(bus.row_fault_detection), 64'(rowv[k]));
            check($sformatf("%s colf[%0d]", tag, k), 64'(bus.column_fault_detection), 64'(colv[k]));
        end
        cycle();
        check({tag, " done"}, 64'(bus.done), 64'd1);
        check({tag, " en_post"}, 64'(bus.detection_en), 64'd0);
        check({tag, " single_post"}, 64'(bus.single_pe_detection), 64'd0);
        check({tag, " rowf_post"}, 64'(bus.row_fault_detection), 64'd0);
        check({tag, " colf_post"}, 64'(bus.column_fault_detection), 64'd0);
        check({tag, " busy_post"}, 64'(bus.busy), 64'd0);
        check({tag, " fault_count"}, 64'(bus.fault_count), 64'(count));
        cycle();
        check({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n               = 1'b0;
        bus.start           = 1'b0;
        bus.result_valid    = 1'b0;
        bus.result_row      = '0;
        bus.result_mismatch = '0;
        bus.test_done       = 1'b0;
        cycle();
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst done", 64'(bus.done), 64'd0);
        check("rst en", 64'(bus.detection_en), 64'd0);
        check("rst addr", 64'(bus.detection_addr), 64'd0);
        check("rst single", 64'(bus.single_pe_detection), 64'd0);
        check("rst rowf", 64'(bus.row_fault_detection), 64'd0);
        check("rst colf", 64'(bus.column_fault_detection), 64'd0);
        check("rst count", 64'(bus.fault_count), 64'd0);
        rst_n = 1'b1;
        cycle();

        // No faults at all
        do_start();
        finish_test();
        run_writes("none", 64'h0, 8'h00, 8'h00, 7'd0);

        // Isolated PE at (2,5)
        do_start();
        send(3'd2, 8'h20, 1'b0, 1'b0);
        finish_test();
        run_writes("single", 64'h0000_0000_0020_0000, 8'h00, 8'h00, 7'd1);

        // Four faulty PEs in row 3
        do_start();
        send(3'd3, 8'h0F, 1'b0, 1'b0);
        finish_test();
`ifdef ROW_COL_CLASSIFY_EN
        run_writes("rowf", 64'h0, 8'h08, 8'h00, 7'd4);
`else
        run_writes("rowf", 64'h0000_0000_0F00_0000, 8'h00, 8'h00, 7'd4);
`endif

        // Column 6 fault on rows 0,1,2,7 plus isolated PE (1,0)
        do_start();
        send(3'd0, 8'h40, 1'b0, 1'b0);
        send(3'd1, 8'h40, 1'b0, 1'b0);
        send(3'd2, 8'h40, 1'b0, 1'b0);
        send(3'd7, 8'h40, 1'b0, 1'b0);
        send(3'd1, 8'h01, 1'b0, 1'b0);
        finish_test();
`ifdef ROW_COL_CLASSIFY_EN
        run_writes("colf", 64'h0000_0000_0000_0100, 8'h00, 8'h40, 7'd5);
`else
        run_writes("colf", 64'h4000_0000_0040_4140, 8'h00, 8'h00, 7'd5);
`endif

        // Sticky OR, with a stray start in ACCUM and a result arriving with test_done
        do_start();
        send(3'd4, 8'h01, 1'b0, 1'b0);
        send(3'd4, 8'h80, 1'b1, 1'b1);
        run_writes("sticky", 64'h0000_0081_0000_0000, 8'h00, 8'h00, 7'd2);

        // Reset while address 4 is on the bus
        do_start();
        send(3'd5, 8'h10, 1'b0, 1'b0);
        finish_test();
        for (int i = 0; i < 6; i++) cycle();
        check("midrst addr_before", 64'(bus.detection_addr), 64'd4);
        check("midrst en_before", 64'(bus.detection_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst en", 64'(bus.detection_en), 64'd0);
        check("midrst busy", 64'(bus.busy), 64'd0);
        check("midrst addr", 64'(bus.detection_addr), 64'd0);
        check("midrst count", 64'(bus.fault_count), 64'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        do_start();
        send(3'd0, 8'h03, 1'b0, 1'b0);
        finish_test();
        run_writes("after_rst", 64'h0000_0000_0000_0003, 8'h00, 8'h00, 7'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fault_diagnosis_writer.md
Name: fault_diagnosis_writer

Overview:
- Collects per-PE mismatch results from the systolic-array self-test and builds an SYSTOLIC_SIZE x SYSTOLIC_SIZE fail map.
- Classifies the fail map into row faults, column faults and isolated single-PE faults.
- Streams the result into the eNVM faulty-PE storage, one row address per cycle, over the detection write interface (detection_en / detection_addr / single_pe_detection / row_fault_detection / column_fault_detection).
- Sits between the test-response comparator and the eNVM; it is the writer side of that storage.

Parameters:
SYSTOLIC_SIZE, 8, array dimension N
ADDR_WIDTH, $clog2(SYSTOLIC_SIZE), row/column index width
ROW_FAULT_THRESHOLD, 4, minimum faulty PEs in a row to declare a row fault
COL_FAULT_THRESHOLD, 4, minimum faulty PEs in a column to declare a column fault
COUNT_WIDTH, $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE)+1, width of fault_count

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  pulse: clear fail map, begin accumulation (honoured only in IDLE)
result_valid  input  1  result_row/result_mismatch valid this cycle
result_row  input  ADDR_WIDTH  row index of reported results
result_mismatch  input  SYSTOLIC_SIZE  bit c=1: PE(row,c) mismatched for current pattern
test_done  input  1  pulse: all patterns applied
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse after last eNVM write
detection_en  output  1  eNVM write strobe
detection_addr  output  ADDR_WIDTH  eNVM row/column address
single_pe_detection  output  SYSTOLIC_SIZE  isolated-PE fault pattern for row detection_addr
row_fault_detection  output  1  row detection_addr is a row fault
column_fault_detection  output  1  column detection_addr is a column fault
fault_count  output  COUNT_WIDTH  total set bits in fail map, valid from CLASSIFY until next start

Behaviour:
- Reset (async, rst_n=0): state=IDLE; fail map, row_fault/col_fault vectors, fault_count, addr counter all 0. busy=0, done=0, detection_en=0, detection_addr=0, single_pe_detection=0, row_fault_detection=0, column_fault_detection=0.
- IDLE: start=1 clears the fail map and fault_count, then moves to ACCUM. All other inputs are ignored.
- ACCUM:
  - result_valid=1: fail_map[result_row] <= fail_map[result_row] | result_mismatch. Sticky; bits never clear in ACCUM.
  - test_done=1: move to CLASSIFY. If result_valid is also high in that cycle, that result is accumulated first.
  - start is ignored.
- CLASSIFY (1 cycle):
  - row_fault[r] = popcount(fail_map[r]) >= ROW_FAULT_THRESHOLD.
  - col_fault[c] = popcount(column c) >= COL_FAULT_THRESHOLD.
  - fault_count = popcount(whole map).
  - All results registered. Next state: WRITE with counter=0.
- WRITE (exactly SYSTOLIC_SIZE cycles, counter k=0..N-1), registered outputs:
  - detection_en=1, detection_addr=k.
  - single_pe_detection = row_fault[k] ? 0 : (fail_map[k] & ~col_fault).
  - row_fault_detection = row_fault[k].
  - column_fault_detection = col_fault[k].
  - The eNVM captures each write on the edge ending that cycle.
  - After k=N-1: detection_en=0 and outputs return to 0, done=1 for one cycle, state returns to IDLE.
- Latency: test_done sampled at edge E0 → first write (addr 0) visible in the cycle after E2 (2 cycles). done follows N+2 cycles after E0.
- result_valid or test_done outside ACCUM: ignored. start outside IDLE: ignored. The counter never wraps, because WRITE exits at N-1.
- Reset mid-operation: immediate return to the reset values. Writes already committed to the eNVM are not undone.

Optional Feature:
ROW_COL_CLASSIFY_EN
- Defined: row and column classification as described above.
- Undefined: row_fault and col_fault are forced to 0, so row_fault_detection and column_fault_detection are always 0 and single_pe_detection equals the raw fail_map[k]. The threshold comparators are not synthesized. CLASSIFY still takes 1 cycle, so timing is unchanged.

Test Plan:
- No faults (N=8): start, then test_done with no result_valid → 8 writes, addr 0..7, all data 0, fault_count=0, done exactly 10 cycles after test_done sampled.
- Single PE: result_row=2, result_mismatch=8'b0010_0000 → addr2 single_pe_detection=8'h20, all other rows 0, no row/col faults, fault_count=1.
- Row fault: result_row=3, result_mismatch=8'h0F → at addr3 row_fault_detection=1 and single_pe_detection=0; fault_count=4.
- Column fault: mismatch 8'h40 on rows 0,1,2,7 plus 8'h01 on row 1 → column_fault_detection=1 at addr6 only; addr1 single_pe_detection=8'h01; rows 0,2,7 give 0; fault_count=5.
- Sticky OR and simultaneous done: row 4 gets 8'h01, then 8'h80 in the same cycle as test_done → addr4 single_pe_detection=8'h81.
- Reset mid-WRITE: deassert rst_n while detection_addr=4 → detection_en=0 and busy=0 asynchronously. A new start/test_done afterwards produces a clean 8-write sequence from addr 0.
